// File: rtl/mem_port_arbiter.sv
// Two-requester round-robin arbiter in front of one single-port data memory.
// Grants are combinational; read data returns to the issuing requester one cycle later.
module mem_port_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_HOLD = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              r0_req,
  input  logic              r0_we,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_wdata,
  input  logic              r1_req,
  input  logic              r1_we,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_wdata,
  output logic              r0_gnt,
  output logic              r1_gnt,
  output logic              r0_rvalid,
  output logic              r1_rvalid,
  output logic [DATA_W-1:0] r0_rdata,
  output logic [DATA_W-1:0] r1_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CNT_W = $clog2(MAX_HOLD + 1);
  localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(MAX_HOLD);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  typedef struct packed {
    logic valid;
    logic owner;
  } rd_tag_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             last, last_nxt;
  rd_tag_t          rd_tag, rd_tag_nxt;
  logic             granted;
  logic             sel;
  logic             same_owner;

  // Grant decision. The holder keeps the port until it reaches MAX_HOLD with the other waiting.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    r0_gnt = 1'b0;
    r1_gnt = 1'b0;
    case (state)
      OWN0: begin
        if (r0_req && (cnt < HOLD_MAX || !r1_req)) r0_gnt = 1'b1;
        else if (r1_req)                            r1_gnt = 1'b1;
      end
      OWN1: begin
        if (r1_req && (cnt < HOLD_MAX || !r0_req)) r1_gnt = 1'b1;
        else if (r0_req)                            r0_gnt = 1'b1;
      end
      default: begin
        if (r0_req && r1_req) begin
          r0_gnt = last;
          r1_gnt = ~last;
        end else begin
          r0_gnt = r0_req;
          r1_gnt = r1_req;
        end
      end
    endcase
  end

  assign granted = r0_gnt | r1_gnt;
  assign sel     = r1_gnt;
  assign mem_en  = granted;

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (r0_gnt) begin
      mem_we    = r0_we;
      mem_addr  = r0_addr;
      mem_wdata = r0_wdata;
    end else if (r1_gnt) begin
      mem_we    = r1_we;
      mem_addr  = r1_addr;
      mem_wdata = r1_wdata;
    end
  end

  assign same_owner = (state == OWN0 && !sel) || (state == OWN1 && sel);

  always_comb begin
    state_nxt  = IDLE;
    cnt_nxt    = '0;
    last_nxt   = last;
    rd_tag_nxt = '0;
    if (granted) begin
      state_nxt = sel ? OWN1 : OWN0;
      last_nxt  = sel;
      if (!same_owner)           cnt_nxt = CNT_W'(1);
      else if (cnt == HOLD_MAX)  cnt_nxt = cnt;
      else                       cnt_nxt = cnt + CNT_W'(1);
      rd_tag_nxt.valid = ~mem_we;
      rd_tag_nxt.owner = sel;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      cnt    <= '0;
      last   <= 1'b1;
      rd_tag <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      last   <= last_nxt;
      rd_tag <= rd_tag_nxt;
    end
  end

  assign r0_rvalid = rd_tag.valid && !rd_tag.owner;
  assign r1_rvalid = rd_tag.valid &&  rd_tag.owner;
  assign r0_rdata  = mem_rdata;
  assign r1_rdata  = mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a small synchronous memory model.
// Inputs change on the falling edge; outputs are sampled 2 time units later.
module tb_mem_port_arbiter;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              r0_req, r0_we, r1_req, r1_we;
  logic [ADDR_W-1:0] r0_addr, r1_addr;
  logic [DATA_W-1:0] r0_wdata, r1_wdata;
  logic              r0_gnt, r1_gnt, r0_rvalid, r1_rvalid;
  logic [DATA_W-1:0] r0_rdata, r1_rdata;
  logic              mem_en, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic [DATA_W-1:0] mem [16];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_HOLD(4)) dut (
    .clk(clk), .rst(rst),
    .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r0_gnt(r0_gnt), .r1_gnt(r1_gnt),
    .r0_rvalid(r0_rvalid), .r1_rvalid(r1_rvalid),
    .r0_rdata(r0_rdata), .r1_rdata(r1_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  // Single-port memory: read data appears the cycle after issue.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr[3:0]] <= mem_wdata;
      else        mem_rdata <= mem[mem_addr[3:0]];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic idle_reqs();
    r0_req = 1'b0; r0_we = 1'b0; r0_addr = '0; r0_wdata = '0;
    r1_req = 1'b0; r1_we = 1'b0; r1_addr = '0; r1_wdata = '0;
  endtask

  task automatic do_reset();
    step();
    idle_reqs();
    rst = 1'b0;
    step();
    rst = 1'b1;
  endtask

  logic [1:0] exp_gnt, prev_gnt;
  int         beats;
  bit         r1_seen;

  initial begin
    rst = 1'b0;
    idle_reqs();
    for (int i = 0; i < 16; i++) mem[i] = '0;
    mem[5] = 32'h1234;
    mem[2] = 32'hA;
    mem[3] = 32'hB;
    mem_rdata = '0;

    // Reset held for 3 cycles: every output quiet.
    for (int i = 0; i < 3; i++) begin
      step(); settle();
      check("rst_ctl", 32'({r0_gnt, r1_gnt, mem_en, mem_we, r0_rvalid, r1_rvalid}), 32'h0);
      check("rst_addr", mem_addr, 32'h0);
    end

    // Single read from r0 right after release.
    step();
    rst = 1'b1;
    r0_req = 1'b1; r0_we = 1'b0; r0_addr = 32'd5;
    settle();
    check("rd_gnt", 32'({r0_gnt, r1_gnt, mem_en, mem_we}), 32'b1010);
    check("rd_addr", mem_addr, 32'd5);
    step();
    idle_reqs();
    settle();
    check("rd_rvalid", 32'({r0_rvalid, r1_rvalid}), 32'b10);
    check("rd_rdata", r0_rdata, 32'h1234);

    // Contention: both read continuously; 4 beats each, r0 first after reset.
    do_reset();
    r0_req = 1'b1; r0_addr = 32'd2;
    r1_req = 1'b1; r1_addr = 32'd3;
    prev_gnt = 2'b00;
    for (int c = 1; c <= 12; c++) begin
      exp_gnt = (c <= 4 || c >= 9) ? 2'b10 : 2'b01;
      settle();
      check($sformatf("cont_gnt%0d", c), 32'({r0_gnt, r1_gnt}), 32'(exp_gnt));
      check($sformatf("cont_rv%0d", c), 32'({r0_rvalid, r1_rvalid}), 32'(prev_gnt));
      if (prev_gnt == 2'b10) check($sformatf("cont_rd%0d", c), r0_rdata, 32'hA);
      if (prev_gnt == 2'b01) check($sformatf("cont_rd%0d", c), r1_rdata, 32'hB);
      prev_gnt = exp_gnt;
      step();
    end
    idle_reqs();

    // Uncontended burst by r1, then r0 breaks in on its first request cycle.
    step();
    r1_req = 1'b1; r1_addr = 32'd3;
    for (int c = 1; c <= 10; c++) begin
      settle();
      check($sformatf("burst_gnt%0d", c), 32'({r0_gnt, r1_gnt}), 32'b01);
      step();
    end
    check("burst_cnt", 32'(dut.cnt), 32'd4);
    r0_req = 1'b1; r0_addr = 32'd2;
    settle();
    check("burst_takeover", 32'({r0_gnt, r1_gnt}), 32'b10);
    step();
    idle_reqs();
    step();

    // Interleaved reads: r0 at t, r1 at t+1.
    r0_req = 1'b1; r0_addr = 32'd2;
    settle();
    check("il_gnt0", 32'({r0_gnt, r1_gnt}), 32'b10);
    step();
    r0_req = 1'b0;
    r1_req = 1'b1; r1_addr = 32'd3;
    settle();
    check("il_gnt1", 32'({r0_gnt, r1_gnt}), 32'b01);
    check("il_rv_t1", 32'({r0_rvalid, r1_rvalid}), 32'b10);
    check("il_rd_t1", r0_rdata, 32'hA);
    step();
    idle_reqs();
    settle();
    check("il_rv_t2", 32'({r0_rvalid, r1_rvalid}), 32'b01);
    check("il_rd_t2", r1_rdata, 32'hB);

    // Write from r1, no rvalid; r0 reads it back.
    step();
    r1_req = 1'b1; r1_we = 1'b1; r1_addr = 32'd7; r1_wdata = 32'hDEADBEEF;
    settle();
    check("wr_ctl", 32'({r1_gnt, mem_en, mem_we}), 32'b111);
    check("wr_addr", mem_addr, 32'd7);
    check("wr_data", mem_wdata, 32'hDEADBEEF);
    step();
    idle_reqs();
    settle();
    check("wr_no_rv", 32'({r0_rvalid, r1_rvalid}), 32'b00);
    check("idle_we", 32'({mem_en, mem_we}), 32'b00);
    check("idle_wdata", mem_wdata, 32'h0);
    step();
    r0_req = 1'b1; r0_addr = 32'd7;
    settle();
    check("rb_gnt", 32'(r0_gnt), 32'd1);
    step();
    idle_reqs();
    settle();
    check("rb_rv", 32'({r0_rvalid, r1_rvalid}), 32'b10);
    check("rb_rd", r0_rdata, 32'hDEADBEEF);

    // Reset during a granted read: the read is dropped and arbitration restarts.
    step();
    r0_req = 1'b1; r0_addr = 32'd5;
    settle();
    check("rr_gnt", 32'(r0_gnt), 32'd1);
    #1;
    rst = 1'b0;
    idle_reqs();
    step();
    settle();
    check("rr_rv_in_rst", 32'({r0_rvalid, r1_rvalid}), 32'b00);
    step();
    rst = 1'b1;
    settle();
    check("rr_rv_after", 32'({r0_rvalid, r1_rvalid}), 32'b00);
    step();
    r0_req = 1'b1; r0_addr = 32'd2;
    r1_req = 1'b1; r1_addr = 32'd3;
    beats = 0;
    r1_seen = 1'b0;
    for (int c = 0; c < 10 && !r1_seen; c++) begin
      settle();
      check($sformatf("rr_onehot%0d", c), 32'(r0_gnt & r1_gnt), 32'd0);
      if (r1_gnt) r1_seen = 1'b1;
      else if (r0_gnt) beats++;
      step();
    end
    check("rr_r1_served", 32'(r1_seen), 32'd1);
    check("rr_r0_beats", 32'(beats), 32'd4);
    idle_reqs();

    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter that shares one single-port, word-addressed data memory between the CPU load/store path (requester 0) and a loader/DMA engine (requester 1). Each cycle it selects at most one requester and drives its access straight onto the memory port. It returns read data one cycle later to the requester that issued the read. Round-robin selection with a bounded hold count gives burst efficiency without starvation.

## Interface
- ADDR_W, 32, memory word-address width
- DATA_W, 32, data word width
- MAX_HOLD, 4, max consecutive beats one requester keeps the port while the other is waiting (≥1)

- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-low reset
- r0_req, r1_req  input  1  access request; held with its qualifiers until granted
- r0_we, r1_we  input  1  1 = write, 0 = read
- r0_addr, r1_addr  input  ADDR_W  word address
- r0_wdata, r1_wdata  input  DATA_W  write data
- r0_gnt, r1_gnt  output  1  access issued this cycle (combinational)
- r0_rvalid, r1_rvalid  output  1  read data valid for that requester (registered)
- r0_rdata, r1_rdata  output  DATA_W  read data; both driven from mem_rdata
- mem_en  output  1  access issued this cycle
- mem_we  output  1  write strobe
- mem_addr  output  ADDR_W  selected address
- mem_wdata  output  DATA_W  selected write data
- mem_rdata  input  DATA_W  memory read data, valid the cycle after issue

## Operation
- State registers:
  - state ∈ {IDLE, OWN0, OWN1}
  - cnt, width clog2(MAX_HOLD+1), saturating at MAX_HOLD
  - last, the most recent granted requester
  - rd_tag, 2 bits: valid plus owner of the read issued in the previous cycle
- Grant decision is combinational on state, cnt, last and the requests:
  - IDLE, one request: grant that requester.
  - IDLE, both requesting: grant the requester ≠ last.
  - OWNx: grant x if rx_req && (cnt < MAX_HOLD || !ry_req). Otherwise grant y if ry_req. Otherwise no grant.
- At most one gnt is high per cycle.
- mem_en = r0_gnt | r1_gnt. mem_we, mem_addr and mem_wdata are muxed from the granted requester.
- When there is no grant: mem_we = 0, and mem_addr and mem_wdata are 0.
- Next-state rules:
  - Grant g: state ← OWNg and last ← g. cnt ← min(cnt+1, MAX_HOLD) if g equals the previous owner, else cnt ← 1.
  - No grant: state ← IDLE and cnt ← 0; last is unchanged.
- Read return:
  - A granted read sets rd_tag ← {1, g}; anything else sets rd_tag ← 0.
  - r{g}_rvalid = rd_tag.valid && rd_tag.owner == g.
  - rdata outputs pass mem_rdata through; they are meaningful only while rvalid is high.
- Writes never produce rvalid.
- Saturated owner: if cnt = MAX_HOLD and the other requester stays idle, the owner continues. The first cycle the other requests, the other is granted.

## Timing
- Reset (rst = 0, asynchronous): state = IDLE, cnt = 0, last = 1 (requester 0 wins the first tie), rd_tag = 0.
  - rvalid outputs are 0 immediately.
  - gnt, mem_en and mem_we are 0 while no request is present.
- Reset mid-operation: any outstanding read is discarded; rvalid is not asserted after reset release.
- Request-to-grant latency is 0 cycles when the port is available, and the access is issued in that same cycle.
- Read data latency: rvalid is asserted exactly 1 cycle after the granted read.
- Throughput is 1 access per cycle. Back-to-back reads from alternating requesters are tagged independently.
- Requester rules:
  - While req = 1 and gnt = 0, the requester holds we, addr and wdata stable.
  - A requester that drops req before being granted is simply not served.
- Worst-case wait for a continuously requesting requester is MAX_HOLD cycles.

## Test plan
- Reset then single read:
  - Stimulus: hold rst = 0 for 3 cycles, then release; r0 reads addr 5 with memory word 5 = 0x1234.
  - Required: all outputs are 0 during reset. r0_gnt, mem_en = 1 and mem_addr = 5 in the issue cycle. Next cycle r0_rvalid = 1, r0_rdata = 0x1234, r1_rvalid = 0.
- Contention, MAX_HOLD = 4:
  - Stimulus: r0 and r1 both request reads continuously from the first cycle after reset.
  - Required: r0 is granted cycles 1–4, r1 is granted cycles 5–8, r0 again cycles 9–12. Never both grants in one cycle.
- Uncontended burst:
  - Stimulus: r1 requests alone for 10 cycles.
  - Required: r1_gnt = 1 on all 10 cycles; cnt saturates at 4.
  - Follow-up: r0 then requests. Required: r0 is granted on that same cycle.
- Interleaved reads:
  - Stimulus: r0 reads addr 2 (word = 0xA) at t; r1 reads addr 3 (word = 0xB) at t+1.
  - Required: r0_rvalid with 0xA at t+1, and r1_rvalid with 0xB at t+2. No cross-delivery.
- Write:
  - Stimulus: r1 writes 0xDEADBEEF to addr 7.
  - Required: mem_we = 1, mem_addr = 7, mem_wdata = 0xDEADBEEF in the grant cycle; no rvalid follows.
  - Check: a later r0 read of addr 7 returns 0xDEADBEEF.
- Reset during read:
  - Stimulus: r0 read granted at t; rst driven to 0 mid-cycle t.
  - Required: r0_rvalid stays 0 at t+1, and state returns to IDLE.
